// File: rtl/pl_pkg.sv
// rtl/pl_pkg.sv - default widths, NOP bubble, IF/ID beat type and field extractors
package pl_pkg;

    localparam int PC_W   = 8;
    localparam int OPC_W  = 4;
    localparam int REG_W  = 2;
    localparam int EA_W   = 8;
    localparam int INST_W = OPC_W + 2 * REG_W + EA_W;

    localparam logic [INST_W-1:0] NOP = '0;

    typedef struct packed {
        logic [PC_W-1:0]   pc2;
        logic [INST_W-1:0] inst;
    } if_id_t;

    function automatic logic [OPC_W-1:0] get_opc(input logic [INST_W-1:0] inst);
        return inst[INST_W-1 -: OPC_W];
    endfunction

    function automatic logic [REG_W-1:0] get_ra(input logic [INST_W-1:0] inst);
        return inst[INST_W-OPC_W-1 -: REG_W];
    endfunction

    function automatic logic [REG_W-1:0] get_rb(input logic [INST_W-1:0] inst);
        return inst[INST_W-OPC_W-REG_W-1 -: REG_W];
    endfunction

    function automatic logic [EA_W-1:0] get_ea(input logic [INST_W-1:0] inst);
        return inst[EA_W-1:0];
    endfunction

endpackage

// File: rtl/pl_skid_slot.sv
// rtl/pl_skid_slot.sv - one IF/ID beat register with valid, load, drop and clear
module pl_skid_slot
    import pl_pkg::*;
#(
    parameter int W = $bits(if_id_t)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clear,
    input  logic         i_load,
    input  logic         i_drop,
    input  logic [W-1:0] i_d,
    output logic         o_valid,
    output logic [W-1:0] o_q
);

    logic         r_valid;
    logic [W-1:0] r_q;

    // reset/clear empty the slot and zero its data; load beats drop so a refill never bubbles
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_valid <= 1'b0;
            r_q     <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_q     <= i_d;
        end else if (i_drop) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_q     = r_q;

endmodule

// File: rtl/pipeline_if_id_reg.sv
// rtl/pipeline_if_id_reg.sv - IF->ID pipeline register with valid/ready, stall, flush; IF_ID_SKID_EN adds a skid slot
module pipeline_if_id_reg #(
    parameter int PC_W  = pl_pkg::PC_W,
    parameter int OPC_W = pl_pkg::OPC_W,
    parameter int REG_W = pl_pkg::REG_W,
    parameter int EA_W  = pl_pkg::EA_W
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [PC_W-1:0]                     PC2_in,
    input  logic [OPC_W+2*REG_W+EA_W-1:0]       inst_in,
    input  logic                                flush,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [PC_W-1:0]                     PC2_out,
    output logic [OPC_W+2*REG_W+EA_W-1:0]       inst_out,
    output logic [OPC_W-1:0]                    opc,
    output logic [REG_W-1:0]                    ra,
    output logic [REG_W-1:0]                    rb,
    output logic [EA_W-1:0]                     ea
);

    localparam int INST_W = OPC_W + 2 * REG_W + EA_W;
    localparam int BEAT_W = PC_W + INST_W;

    logic              w_accept;
    logic              w_consume;
    logic              w_main_free;
    logic              w_main_valid;
    logic              w_main_load;
    logic [BEAT_W-1:0] w_main_d;
    logic [BEAT_W-1:0] w_main_q;
    logic [BEAT_W-1:0] w_new_beat;

    assign w_new_beat  = {PC2_in, inst_in};
    assign w_accept    = in_valid & in_ready;
    assign w_consume   = w_main_valid & out_ready;
    // main register can take a beat this edge: empty, or its occupant leaves now
    assign w_main_free = ~w_main_valid | out_ready;

`ifdef IF_ID_SKID_EN
    logic              w_skid_valid;
    logic              w_skid_load;
    logic              w_skid_drop;
    logic [BEAT_W-1:0] w_skid_q;

    // ready depends only on skid occupancy; flush always swallows the incoming beat
    assign in_ready    = ~rst & (flush | ~w_skid_valid);
    // skid content is older than any incoming beat, so it refills main first
    assign w_main_load = w_main_free & (w_skid_valid | w_accept);
    assign w_main_d    = w_skid_valid ? w_skid_q : w_new_beat;
    // new beat parks in skid while main is stalled, or replaces skid as it moves up
    assign w_skid_load = w_accept & (~w_main_free | w_skid_valid);
    assign w_skid_drop = w_main_free & w_skid_valid;

    pl_skid_slot #(.W(BEAT_W)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_clear (flush),
        .i_load  (w_skid_load),
        .i_drop  (w_skid_drop),
        .i_d     (w_new_beat),
        .o_valid (w_skid_valid),
        .o_q     (w_skid_q)
    );
`else
    // without skid storage the stage can only accept when main frees up this edge
    assign in_ready    = ~rst & (flush | w_main_free);
    assign w_main_load = w_accept;
    assign w_main_d    = w_new_beat;
`endif

    pl_skid_slot #(.W(BEAT_W)) u_main (
        .clk     (clk),
        .rst     (rst),
        .i_clear (flush),
        .i_load  (w_main_load),
        .i_drop  (w_consume),
        .i_d     (w_main_d),
        .o_valid (w_main_valid),
        .o_q     (w_main_q)
    );

    assign out_valid = w_main_valid;
    assign PC2_out   = w_main_q[BEAT_W-1 -: PC_W];
    assign inst_out  = w_main_q[INST_W-1:0];
    assign opc       = inst_out[INST_W-1 -: OPC_W];
    assign ra        = inst_out[INST_W-OPC_W-1 -: REG_W];
    assign rb        = inst_out[INST_W-OPC_W-REG_W-1 -: REG_W];
    assign ea        = inst_out[EA_W-1:0];

endmodule
